// File: rtl/gpu_pkg.sv
// gpu_pkg: shared warp-count constants, warp mask type and one-hot decode helper
package gpu_pkg;
    localparam int NUM_WARPS    = 8;
    localparam int LOGNUM_WARPS = $clog2(NUM_WARPS);
    typedef logic [NUM_WARPS-1:0] warp_mask_t;
    function automatic logic [LOGNUM_WARPS-1:0] onehot_idx(input warp_mask_t m);
        logic [LOGNUM_WARPS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_WARPS; i++)
            r = m[i] ? r | LOGNUM_WARPS'(i) : r;
        return r;
    endfunction
endpackage

// File: rtl/fs_rotate_pick.sv
// fs_rotate_pick: circular find-first over a warp mask, scanning upward from start
module fs_rotate_pick
    import gpu_pkg::*;
(
    input  warp_mask_t              req,
    input  logic [LOGNUM_WARPS-1:0] start,
    output warp_mask_t              grant,
    output logic                    found
);
    logic [LOGNUM_WARPS-1:0] idx;
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = start;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = start + LOGNUM_WARPS'(i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/warp_fetch_scheduler.sv
// warp_fetch_scheduler: round-robin selection of up to two warps to fetch per cycle
// FS_DUAL_GRANT_EN enables the second (slot 1) grant; otherwise Grant1_FS_IF is tied low.
module warp_fetch_scheduler
    import gpu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Activate_TM_FS,
    input  logic [LOGNUM_WARPS-1:0] Activate_WarpID_TM_FS,
    input  logic                    Exit_IU_FS,
    input  logic [LOGNUM_WARPS-1:0] Exit_WarpID_IU_FS,
    input  warp_mask_t              Req_IB_FS,
    input  warp_mask_t              Stall_SIMT_FS,
    input  warp_mask_t              Deposit_IB_FS,
    input  warp_mask_t              Flush_SIMT_FS,
    output warp_mask_t              Grant0_FS_IF,
    output warp_mask_t              Grant1_FS_IF,
    output warp_mask_t              Active_FS,
    output warp_mask_t              InFlight_FS
);
    warp_mask_t active, inflight, grant0_q, grant1_q;
    warp_mask_t act_dec, exit_dec, elig, g0, g1, clear;
    logic [LOGNUM_WARPS-1:0] ptr, ptr_n, g0_idx, g1_idx, start1;
    logic f0, f1;
    assign act_dec  = warp_mask_t'(Activate_TM_FS) << Activate_WarpID_TM_FS;
    assign exit_dec = warp_mask_t'(Exit_IU_FS) << Exit_WarpID_IU_FS;
    // an exit sampled this edge already removes the warp from this edge's pick
    assign elig     = active & Req_IB_FS & ~Stall_SIMT_FS & ~inflight & ~exit_dec;
    assign clear    = Deposit_IB_FS | Flush_SIMT_FS | exit_dec;
    fs_rotate_pick u_pick0 (.req(elig), .start(ptr), .grant(g0), .found(f0));
    assign g0_idx = onehot_idx(g0);
    assign start1 = g0_idx + 1'b1;
`ifdef FS_DUAL_GRANT_EN
    fs_rotate_pick u_pick1 (.req(elig & ~g0), .start(start1), .grant(g1), .found(f1));
`else
    assign g1 = '0;
    assign f1 = 1'b0;
`endif
    assign g1_idx = onehot_idx(g1);
    assign ptr_n  = f1 ? g1_idx + 1'b1 : f0 ? start1 : ptr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active   <= '0;
            inflight <= '0;
            grant0_q <= '0;
            grant1_q <= '0;
            ptr      <= '0;
        end else begin
            active   <= (active | act_dec) & ~exit_dec;
            inflight <= (inflight | g0 | g1) & ~clear;
            grant0_q <= g0;
            grant1_q <= g1;
            ptr      <= ptr_n;
        end
    end
    assign Grant0_FS_IF = grant0_q;
    assign Grant1_FS_IF = grant1_q;
    assign Active_FS    = active;
    assign InFlight_FS  = inflight;
endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// tb_warp_fetch_scheduler: directed checks of fetch grants, rotation, inflight and active tracking
module tb_warp_fetch_scheduler;
    import gpu_pkg::*;
`ifdef FS_DUAL_GRANT_EN
    localparam bit DUAL = 1'b1;
    localparam logic [7:0] E0 [5] = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h01};
    localparam logic [7:0] E1 [5] = '{8'h02, 8'h08, 8'h20, 8'h80, 8'h02};
`else
    localparam bit DUAL = 1'b0;
    localparam logic [7:0] E0 [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    localparam logic [7:0] E1 [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    logic clk = 1'b0, rst = 1'b0, act = 1'b0, ext = 1'b0;
    logic [LOGNUM_WARPS-1:0] act_id = '0, ext_id = '0;
    warp_mask_t req = '0, stall = '0, dep = '0, flush = '0;
    warp_mask_t g0, g1, act_o, inf_o, p1, p2;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    warp_fetch_scheduler dut (
        .clk(clk), .rst(rst),
        .Activate_TM_FS(act), .Activate_WarpID_TM_FS(act_id),
        .Exit_IU_FS(ext), .Exit_WarpID_IU_FS(ext_id),
        .Req_IB_FS(req), .Stall_SIMT_FS(stall),
        .Deposit_IB_FS(dep), .Flush_SIMT_FS(flush),
        .Grant0_FS_IF(g0), .Grant1_FS_IF(g1),
        .Active_FS(act_o), .InFlight_FS(inf_o)
    );
    task automatic tick();
        @(posedge clk);
        #1;
        act = 1'b0; ext = 1'b0; dep = '0; flush = '0;
    endtask
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask
    task automatic activate(input int id);
        act = 1'b1; act_id = LOGNUM_WARPS'(id);
        tick();
    endtask
    task automatic do_reset();
        req = '0; stall = '0; rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask
    initial begin
        tick(); tick();
        chk("rst_g0", g0, 8'h00);
        chk("rst_g1", g1, 8'h00);
        chk("rst_act", act_o, 8'h00);
        chk("rst_inf", inf_o, 8'h00);
        rst = 1'b1;
        // warps 0 and 3 granted together once both are active
        activate(0); activate(3);
        chk("t1_act", act_o, 8'h09);
        chk("t1_idle", g0, 8'h00);
        req = 8'hFF; tick();
        chk("t1_g0", g0, 8'h01);
        chk("t1_g1", g1, DUAL ? 8'h08 : 8'h00);
        tick();
        chk("t1_g0b", g0, DUAL ? 8'h00 : 8'h08);
        tick();
        chk("t1_quiet0", g0, 8'h00);
        chk("t1_quiet1", g1, 8'h00);
        chk("t1_inf", inf_o, 8'h09);
        dep = 8'h09; tick();
        chk("t1_dep_inf", inf_o, 8'h00);
        chk("t1_dep_g0", g0, 8'h00);
        tick();
        chk("t1_reg0", g0, 8'h01);
        chk("t1_reg1", g1, DUAL ? 8'h08 : 8'h00);
        // full rotation with deposits two cycles after each grant
        do_reset();
        for (int i = 0; i < NUM_WARPS; i++) activate(i);
        chk("t2_act", act_o, 8'hFF);
        req = 8'hFF; p1 = '0; p2 = '0;
        for (int k = 0; k < 5; k++) begin
            dep = p2;
            tick();
            chk($sformatf("t2_g0_%0d", k), g0, E0[k]);
            chk($sformatf("t2_g1_%0d", k), g1, E1[k]);
            p2 = p1; p1 = g0 | g1;
        end
        // wrap-around from ptr 7
        do_reset();
        activate(1); activate(6); activate(7);
        req = 8'h40; tick();
        chk("t3_w6", g0, 8'h40);
        req = 8'h80; dep = 8'h40; tick();
        chk("t3_w7_g0", g0, 8'h80);
        chk("t3_w7_g1", g1, 8'h00);
        req = 8'h00; dep = 8'h80; tick();
        chk("t3_none", g0, 8'h00);
        chk("t3_inf0", inf_o, 8'h00);
        req = 8'h40; tick();
        chk("t3_w6b", g0, 8'h40);
        req = 8'h82; dep = 8'h40; tick();
        chk("t3_wrap_g0", g0, 8'h80);
        chk("t3_wrap_g1", g1, DUAL ? 8'h02 : 8'h00);
        req = 8'h00; dep = 8'h82; tick();
        chk("t3_inf1", inf_o, 8'h00);
        req = 8'hC2; tick();
        chk("t3_ptr_g0", g0, DUAL ? 8'h40 : 8'h02);
        chk("t3_ptr_g1", g1, DUAL ? 8'h80 : 8'h00);
        // flush under stall
        do_reset();
        activate(2);
        req = 8'h04; tick();
        chk("t4_grant", g0, 8'h04);
        flush = 8'h04; stall = 8'h04; tick();
        chk("t4_flush_inf", inf_o, 8'h00);
        chk("t4_flush_g0", g0, 8'h00);
        tick();
        chk("t4_stalled", g0, 8'h00);
        stall = 8'h00; tick();
        chk("t4_regrant", g0, 8'h04);
        chk("t4_regrant_inf", inf_o, 8'h04);
        tick();
        chk("t4_pulse", g0, 8'h00);
        // activate/exit interactions
        do_reset();
        activate(4);
        act = 1'b1; act_id = 3'd5; ext = 1'b1; ext_id = 3'd5; tick();
        chk("t5_act_exit", act_o, 8'h10);
        req = 8'h10; tick();
        chk("t5_g4", g0, 8'h10);
        chk("t5_inf4", inf_o, 8'h10);
        ext = 1'b1; ext_id = 3'd4; tick();
        chk("t5_exit_act", act_o, 8'h00);
        chk("t5_exit_inf", inf_o, 8'h00);
        dep = 8'h10; tick();
        chk("t5_dep_inf", inf_o, 8'h00);
        chk("t5_dep_act", act_o, 8'h00);
        req = 8'h08; activate(3);
        ext = 1'b1; ext_id = 3'd3; tick();
        chk("t5_exit_supp", g0, 8'h00);
        chk("t5_exit_act3", act_o, 8'h00);
        // activate latency and asynchronous reset mid-pulse
        do_reset();
        req = 8'hFF; activate(0);
        chk("t6_first", g0, 8'h00);
        tick();
        chk("t6_second", g0, 8'h01);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_g0", g0, 8'h00);
        chk("t6_async_act", act_o, 8'h00);
        chk("t6_async_inf", inf_o, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/warp_fetch_scheduler.md
# warp_fetch_scheduler

Selects which warps fetch each cycle. It issues up to two one-hot fetch grants, feeding the dual fetch/decode slots (ID0, ID1). Selection is round-robin among warps that are eligible: active, given room by the I-buffer, not stalled by SIMT, and with no fetch already in flight. It sits between the thread manager, I-buffer, SIMT stack and issue unit on one side and the Fetch_Decode PC logic on the other, and it replaces the raw I-buffer request as the PC-advance qualifier.

## Interface
- NUM_WARPS, 8, number of hardware warps
- LOGNUM_WARPS, $clog2(NUM_WARPS), warp ID width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- Activate_TM_FS  in  1  thread manager starts a warp this cycle
- Activate_WarpID_TM_FS  in  LOGNUM_WARPS  warp being started
- Exit_IU_FS  in  1  exit instruction granted by the issue unit
- Exit_WarpID_IU_FS  in  LOGNUM_WARPS  exiting warp
- Req_IB_FS  in  NUM_WARPS  I-buffer has a free slot for warp w
- Stall_SIMT_FS  in  NUM_WARPS  SIMT holds warp w
- Deposit_IB_FS  in  NUM_WARPS  decoded instruction for warp w written into the I-buffer
- Flush_SIMT_FS  in  NUM_WARPS  PC redirect for warp w; any in-flight fetch is discarded
- Grant0_FS_IF  out  NUM_WARPS  one-hot fetch grant, slot 0; all zero when idle
- Grant1_FS_IF  out  NUM_WARPS  one-hot fetch grant, slot 1; all zero when idle
- Active_FS  out  NUM_WARPS  per-warp active flags
- InFlight_FS  out  NUM_WARPS  per-warp fetch-outstanding flags

## Operation
- State per warp: active[w] and inflight[w]. Global state: a round-robin pointer ptr of LOGNUM_WARPS bits.
- Eligibility: eligible[w] = active[w] & Req_IB_FS[w] & ~Stall_SIMT_FS[w] & ~inflight[w].
- Slot 0 selection: g0 is the first eligible warp found by scanning upward from ptr, with modulo NUM_WARPS wrap.
- Slot 1 selection: g1 is the next eligible warp after g0 in the same scan. g1 never equals g0.
- If there are no eligible warps, neither slot is granted. If there is exactly one, only slot 0 is granted.
- Pointer update:
  - ptr advances to (last granted warp + 1) mod NUM_WARPS.
  - The last granted warp is g1 when slot 1 fires, otherwise g0.
  - ptr is unchanged when nothing is granted.
- inflight[w] is set when w is granted.
- inflight[w] is cleared by Deposit_IB_FS[w], Flush_SIMT_FS[w] or an exit of w.
- If set and clear of inflight[w] coincide, clear wins.
- active[w] is set by an activate of w and cleared by an exit of w.
- Activating an already-active warp is ignored and leaves inflight unchanged.
- Activate and exit of the same warp in the same cycle: exit wins, and the warp ends inactive.
- Deposit or flush for a warp whose inflight is already clear: ignored.

## Timing
- Grants are registered. Inputs sampled at edge N produce Grant0/1 valid throughout cycle N+1.
- Grants are single-cycle pulses.
- The same warp cannot be granted in consecutive cycles: inflight blocks it from N+1 until the clearing edge.
- Minimum re-grant interval: grant at N, deposit sampled at edge M, next grant at M+1.
- A newly activated warp is first grantable at the edge after the activate edge, so its grant appears two cycles after the activate is sampled.
- An exit sampled at edge N suppresses that warp from the grant computed at the same edge.
- Reset values: Grant0_FS_IF = 0, Grant1_FS_IF = 0, Active_FS = 0, InFlight_FS = 0, ptr = 0.
- Reset asserted mid-operation clears all state immediately. Any grant pulse in progress is dropped.

## Configuration
- FS_DUAL_GRANT_EN defined:
  - Slot 1 is selected as described above.
  - Up to two grants per cycle.
- FS_DUAL_GRANT_EN undefined:
  - Grant1_FS_IF is tied to 0.
  - Only g0 is computed, and ptr = g0 + 1 after each grant.
  - Eligibility and inflight behaviour are unchanged.

## Structure
- Shared package gpu_pkg holds NUM_WARPS, LOGNUM_WARPS and a warp_mask_t typedef.
- Sub-module fs_rotate_pick:
  - Combinational circular find-first from a start index.
  - Outputs a one-hot result plus a found flag.
  - Instantiated twice: the second instance starts at g0 + 1 with g0 masked off.

## Test plan
- Reset release, activate warps 0 and 3, Req = 0xFF, no stalls:
  - Grants 0x01 (slot 0) and 0x08 (slot 1) one cycle after both are active.
  - ptr = 4 afterwards; no further grants until a deposit.
- Active = 0xFF, all eligible, a deposit returned two cycles after every grant:
  - Grant pairs rotate {0,1}, {2,3}, {4,5}, {6,7}, {0,1}.
  - No warp is granted twice within a window of 4 grant cycles.
- Only warp 7 eligible with ptr = 7, then warps 7 and 1 eligible:
  - Slot 0 = 0x80 and slot 1 = 0, then slot 0 = 0x80 and slot 1 = 0x02 after the wrap.
  - ptr = 0, then ptr = 2.
- Warp 2 in flight, Flush_SIMT_FS = 0x04 together with Stall_SIMT_FS[2]:
  - InFlight clears and no grant follows.
  - After the stall drops, warp 2 is granted the next cycle.
- Same-cycle activate and exit of warp 5, then exit of an in-flight warp 4:
  - Active[5] = 0; Active[4] and InFlight[4] clear.
  - A later deposit for warp 4 has no effect.
- Build without FS_DUAL_GRANT_EN, Active = 0xFF:
  - Grant1_FS_IF stays 0.
  - Grant0 sequence is 0x01, 0x02, 0x04, … with deposits returned promptly.
